// File: rtl/tlul_host_mux_pkg.sv
// Shared types for the multi-host TL-UL adapter: TL-UL channel structs, opcode encoding
// and integrity helpers (the integrity path is enabled by TLUL_HOST_MUX_INTG_EN).
package tlul_host_mux_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_SZW = 2;
  localparam int TL_DBW = 4;

  localparam logic [3:0] MuBi4True  = 4'h6;
  localparam logic [3:0] MuBi4False = 4'h9;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [4:0] rsvd;
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    tl_a_user_t        a_user;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    tl_d_user_t        d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } host_req_t;

  function automatic tl_a_op_e encode_opcode(input logic we, input logic [3:0] be);
    tl_a_op_e op;
    if (!we) begin
      op = Get;
    end else if (be == 4'hF) begin
      op = PutFullData;
    end else begin
      op = PutPartialData;
    end
    return op;
  endfunction

  // Interleaved parity fold, inverted so an all-zero word never yields an all-zero code.
  function automatic logic [6:0] intg_fold(input logic [63:0] d);
    logic [6:0] p;
    p = 7'h00;
    for (int i = 0; i < 64; i++) begin
      p[i % 7] = p[i % 7] ^ d[i];
    end
    return ~p;
  endfunction

  function automatic logic [6:0] cmd_intg_gen(input logic [3:0] instr_type, input logic [31:0] addr,
                                              input tl_a_op_e op, input logic [3:0] mask);
    return intg_fold(64'({instr_type, addr, op, mask}));
  endfunction

  function automatic logic [6:0] data_intg_gen(input logic [31:0] data);
    return intg_fold(64'(data));
  endfunction

  function automatic logic [6:0] rsp_intg_gen(input tl_d_op_e op, input logic [1:0] size,
                                              input logic err);
    return intg_fold(64'({op, size, err}));
  endfunction

  localparam logic [6:0] CmdIntgZero  = intg_fold(64'h0);
  localparam logic [6:0] DataIntgZero = data_intg_gen(32'h0);

  function automatic bit src_width_ok(input int host_w, input int slot_w);
    return (host_w + slot_w) <= TL_AIW;
  endfunction

endpackage

// File: rtl/tlul_host_mux_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves past the winner on advance.
module tlul_host_mux_rr_arb #(
  parameter int NumHosts = 2,
  localparam int IdxW = (NumHosts > 1) ? $clog2(NumHosts) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumHosts-1:0] req_i,
  input  logic                advance_i,
  output logic [NumHosts-1:0] gnt_o,
  output logic [IdxW-1:0]     idx_o
);

  logic [IdxW-1:0] ptr_r;
  logic            found_s;

  // First requester at or after the pointer wins.
  always_comb begin
    found_s = 1'b0;
    idx_o   = ptr_r;
    for (int off = 0; off < NumHosts; off++) begin
      int cand;
      cand = (int'(ptr_r) + off) % NumHosts;
      if (!found_s && req_i[cand]) begin
        found_s = 1'b1;
        idx_o   = IdxW'(cand);
      end else begin
        found_s = found_s;
      end
    end
    gnt_o = found_s ? (NumHosts'(1) << idx_o) : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_r <= '0;
    end else if (advance_i) begin
      ptr_r <= (idx_o == IdxW'(NumHosts - 1)) ? '0 : idx_o + IdxW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/tlul_host_mux_adapter.sv
// Merges NumHosts req/gnt/rvalid channels onto one TL-UL host port with source-ID routing.
// Optional integrity generation/checking is enabled by defining TLUL_HOST_MUX_INTG_EN.
module tlul_host_mux_adapter
  import tlul_host_mux_pkg::*;
#(
  parameter int                  NumHosts  = 2,
  parameter int                  MaxReqs   = 2,
  parameter logic [NumHosts-1:0] InstrMask = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumHosts-1:0]      req_i,
  output logic [NumHosts-1:0]      gnt_o,
  input  logic [NumHosts-1:0][31:0] addr_i,
  input  logic [NumHosts-1:0]      we_i,
  input  logic [NumHosts-1:0][31:0] wdata_i,
  input  logic [NumHosts-1:0][3:0] be_i,
  output logic [NumHosts-1:0]      valid_o,
  output logic [31:0]              rdata_o,
  output logic                     err_o,
  output logic                     unexp_rsp_o,
  output logic                     intg_err_o,
  output tl_h2d_t                  tl_o,
  input  tl_d2h_t                  tl_i
);

  localparam int HostIdW = (NumHosts > 1) ? $clog2(NumHosts) : 1;
  localparam int SlotW   = (MaxReqs > 1) ? $clog2(MaxReqs) : 1;
  localparam logic [SlotW:0]   CntMax  = (SlotW + 1)'(MaxReqs);
  localparam logic [SlotW:0]   CntOne  = (SlotW + 1)'(1);
  localparam logic [SlotW-1:0] SlotOne = SlotW'(1);

  if (!src_width_ok(HostIdW, SlotW)) begin : g_src_width_err
    $error("HostIdW + SlotW exceeds the TL-UL source width");
  end

  logic [SlotW:0]      cnt_r  [NumHosts];
  logic [SlotW-1:0]    wptr_r [NumHosts];
  logic [SlotW-1:0]    rptr_r [NumHosts];
  logic [NumHosts-1:0] eligible_s, grant_s, hit_s, inc_s;
  logic [HostIdW-1:0]  win_s, d_host_s;
  logic [SlotW-1:0]    d_slot_s;
  logic                a_valid_s, accept_s, any_hit_s, intg_bad_s;
  host_req_t           win_req_s;
  logic                unused_tl_s;

  // A host stops competing once it has MaxReqs requests in flight.
  always_comb begin
    for (int h = 0; h < NumHosts; h++) begin
      eligible_s[h] = !rst_i && req_i[h] && (cnt_r[h] < CntMax);
    end
  end

  tlul_host_mux_rr_arb #(.NumHosts(NumHosts)) u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (eligible_s),
    .advance_i(accept_s),
    .gnt_o    (grant_s),
    .idx_o    (win_s)
  );

  assign a_valid_s = |eligible_s;
  assign accept_s  = a_valid_s && tl_i.a_ready;
  assign gnt_o     = accept_s ? grant_s : '0;
  assign inc_s     = gnt_o;

  always_comb begin
    win_req_s.addr  = addr_i[win_s];
    win_req_s.we    = we_i[win_s];
    win_req_s.wdata = wdata_i[win_s];
    win_req_s.be    = be_i[win_s];
  end

  always_comb begin
    tl_o                   = '0;
    tl_o.a_valid           = a_valid_s;
    tl_o.a_opcode          = encode_opcode(win_req_s.we, win_req_s.be);
    tl_o.a_size            = 2'd2;
    tl_o.a_source          = TL_AIW'({win_s, wptr_r[win_s]});
    tl_o.a_address         = {win_req_s.addr[31:2], 2'b00};
    tl_o.a_mask            = win_req_s.be;
    tl_o.a_data            = win_req_s.wdata;
    tl_o.a_user.instr_type = InstrMask[win_s] ? MuBi4True : MuBi4False;
`ifdef TLUL_HOST_MUX_INTG_EN
    tl_o.a_user.cmd_intg   = cmd_intg_gen(tl_o.a_user.instr_type, tl_o.a_address,
                                          tl_o.a_opcode, tl_o.a_mask);
    tl_o.a_user.data_intg  = data_intg_gen(tl_o.a_data);
`else
    tl_o.a_user.cmd_intg   = CmdIntgZero;
    tl_o.a_user.data_intg  = DataIntgZero;
`endif
    tl_o.d_ready           = 1'b1;
  end

  assign d_host_s = tl_i.d_source[HostIdW+SlotW-1:SlotW];
  assign d_slot_s = tl_i.d_source[SlotW-1:0];

  // A response is accepted only for the oldest outstanding slot of its host.
  always_comb begin
    for (int h = 0; h < NumHosts; h++) begin
      hit_s[h] = !rst_i && tl_i.d_valid && (d_host_s == HostIdW'(h)) &&
                 (cnt_r[h] != '0) && (d_slot_s == rptr_r[h]);
    end
  end

`ifdef TLUL_HOST_MUX_INTG_EN
  assign intg_bad_s = tl_i.d_valid &&
      ((tl_i.d_user.rsp_intg != rsp_intg_gen(tl_i.d_opcode, tl_i.d_size, tl_i.d_error)) ||
       (tl_i.d_user.data_intg != data_intg_gen(tl_i.d_data)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      intg_err_o <= 1'b0;
    end else begin
      intg_err_o <= intg_err_o | intg_bad_s;
    end
  end
`else
  assign intg_bad_s = 1'b0;
  assign intg_err_o = 1'b0;
`endif

  assign any_hit_s   = |hit_s;
  assign valid_o     = hit_s;
  assign rdata_o     = any_hit_s ? tl_i.d_data : '0;
  assign err_o       = any_hit_s && (tl_i.d_error || intg_bad_s);
  assign unexp_rsp_o = !rst_i && tl_i.d_valid && !any_hit_s;

  // Simultaneous accept and response leave the count alone but move both pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int h = 0; h < NumHosts; h++) begin
        cnt_r[h]  <= '0;
        wptr_r[h] <= '0;
        rptr_r[h] <= '0;
      end
    end else begin
      for (int h = 0; h < NumHosts; h++) begin
        case ({inc_s[h], hit_s[h]})
          2'b10:   cnt_r[h] <= cnt_r[h] + CntOne;
          2'b01:   cnt_r[h] <= cnt_r[h] - CntOne;
          default: cnt_r[h] <= cnt_r[h];
        endcase
        wptr_r[h] <= inc_s[h] ? wptr_r[h] + SlotOne : wptr_r[h];
        rptr_r[h] <= hit_s[h] ? rptr_r[h] + SlotOne : rptr_r[h];
      end
    end
  end

  assign unused_tl_s = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_sink,
                         tl_i.d_user, tl_i.d_source};

endmodule

// File: tb/tb_tlul_host_mux_adapter.sv
// Directed bench for tlul_host_mux_adapter (NumHosts=2, MaxReqs=2, source = {host, slot}).
module tb_tlul_host_mux_adapter;
  import tlul_host_mux_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req, gnt, we, valid;
  logic [1:0][31:0] addr, wdata;
  logic [1:0][3:0]  be;
  logic [31:0]      rdata;
  logic             err, unexp, intg_err;
  tl_h2d_t          tl_h;
  tl_d2h_t          tl_d;
  int               n_checks = 0;
  int               n_fail = 0;

  tlul_host_mux_adapter #(.NumHosts(2), .MaxReqs(2), .InstrMask(2'b00)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .wdata_i(wdata), .be_i(be), .valid_o(valid), .rdata_o(rdata), .err_o(err),
    .unexp_rsp_o(unexp), .intg_err_o(intg_err), .tl_o(tl_h), .tl_i(tl_d)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rsp(input logic v, input logic [7:0] src, input logic [31:0] data,
                         input logic e);
    tl_d.d_valid          = v;
    tl_d.d_source         = src;
    tl_d.d_data           = data;
    tl_d.d_error          = e;
    tl_d.d_opcode         = AccessAckData;
    tl_d.d_size           = 2'd2;
    tl_d.d_user.rsp_intg  = rsp_intg_gen(AccessAckData, 2'd2, e);
    tl_d.d_user.data_intg = data_intg_gen(data);
  endtask

  logic [1:0]  exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [7:0]  exp_src [4] = '{8'h00, 8'h02, 8'h01, 8'h03};
  logic [31:0] rsp_dat [4] = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333};
  logic        rsp_err [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [7:0]  drn_src [3] = '{8'h01, 8'h00, 8'h02};
  logic [1:0]  drn_vld [3] = '{2'b01, 2'b01, 2'b10};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = 2'b00; we = 2'b00; addr = '0; wdata = '0; be = '0;
    tl_d = '0; tl_d.a_ready = 1'b1;
    set_rsp(1'b0, 8'h00, 32'h0, 1'b0);
    step(); step();

    // Outputs stay quiet while reset is held, even with activity on the inputs.
    req = 2'b11;
    set_rsp(1'b1, 8'h00, 32'h1234_5678, 1'b1);
    #1;
    check_eq("rst_gnt", gnt, 2'b00);
    check_eq("rst_avalid", tl_h.a_valid, 1'b0);
    check_eq("rst_valid", valid, 2'b00);
    check_eq("rst_unexp", unexp, 1'b0);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_intg", intg_err, 1'b0);
    step();
    rst = 1'b0; req = 2'b00;
    set_rsp(1'b0, 8'h00, 32'h0, 1'b0);
    #1;
    check_eq("idle_avalid", tl_h.a_valid, 1'b0);
    check_eq("idle_dready", tl_h.d_ready, 1'b1);
    step();

    // Both hosts request continuously: alternating grants, slot IDs advance per host.
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("rr_gnt%0d", i), gnt, exp_gnt[i]);
      check_eq($sformatf("rr_src%0d", i), tl_h.a_source, exp_src[i]);
      step();
    end
    #1;
    check_eq("full_gnt", gnt, 2'b00);
    check_eq("full_avalid", tl_h.a_valid, 1'b0);
    step();

    req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      set_rsp(1'b1, exp_src[i], rsp_dat[i], rsp_err[i]);
      #1;
      check_eq($sformatf("drain_valid%0d", i), valid, exp_gnt[i]);
      check_eq($sformatf("drain_rdata%0d", i), rdata, rsp_dat[i]);
      check_eq($sformatf("drain_err%0d", i), err, rsp_err[i]);
      check_eq($sformatf("drain_unexp%0d", i), unexp, 1'b0);
      step();
    end
    set_rsp(1'b0, 8'h00, 32'h0, 1'b0);
    #1;
    check_eq("drain_done_valid", valid, 2'b00);
    step();

    // Host0 saturates at two outstanding; host1 still served; one response reopens host0.
    req = 2'b01;
    #1; check_eq("sat_gnt_a", gnt, 2'b01); check_eq("sat_src_a", tl_h.a_source, 8'h00);
    step();
    #1; check_eq("sat_gnt_b", gnt, 2'b01); check_eq("sat_src_b", tl_h.a_source, 8'h01);
    step();
    req = 2'b11;
    #1; check_eq("sat_gnt_h1", gnt, 2'b10); check_eq("sat_src_h1", tl_h.a_source, 8'h02);
    step();
    req = 2'b01;
    set_rsp(1'b1, 8'h00, 32'h0BAD_F00D, 1'b0);
    #1; check_eq("sat_gnt_blk", gnt, 2'b00); check_eq("sat_rsp_valid", valid, 2'b01);
    step();
    set_rsp(1'b0, 8'h00, 32'h0, 1'b0);
    #1; check_eq("sat_regnt", gnt, 2'b01); check_eq("sat_regnt_src", tl_h.a_source, 8'h00);
    step();
    req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      set_rsp(1'b1, drn_src[i], 32'hC0DE_0000 + i, 1'b0);
      #1;
      check_eq($sformatf("sat_drain%0d", i), valid, drn_vld[i]);
      step();
    end

    // Response to host1 with nothing outstanding is dropped as a one-cycle pulse.
    set_rsp(1'b1, 8'h03, 32'hFFFF_0000, 1'b0);
    #1;
    check_eq("unexp_valid", valid, 2'b00);
    check_eq("unexp_pulse", unexp, 1'b1);
    check_eq("unexp_rdata", rdata, 32'h0);
    step();
    set_rsp(1'b0, 8'h00, 32'h0, 1'b0);
    #1; check_eq("unexp_clear", unexp, 1'b0);
    step();
    req = 2'b10;
    #1; check_eq("unexp_nochg_gnt", gnt, 2'b10); check_eq("unexp_nochg_src", tl_h.a_source, 8'h03);
    step();

    // Same-cycle accept and response on host1 keeps its count at one.
    set_rsp(1'b1, 8'h03, 32'h5555_AAAA, 1'b0);
    #1;
    check_eq("same_gnt", gnt, 2'b10);
    check_eq("same_src", tl_h.a_source, 8'h02);
    check_eq("same_valid", valid, 2'b10);
    check_eq("same_rdata", rdata, 32'h5555_AAAA);
    step();
    req = 2'b00;
    set_rsp(1'b1, 8'h02, 32'h1357_9BDF, 1'b0);
    #1; check_eq("same_cnt1_valid", valid, 2'b10);
    step();
    #1; check_eq("same_cnt0_valid", valid, 2'b00); check_eq("same_cnt0_unexp", unexp, 1'b1);
    step();
    set_rsp(1'b0, 8'h00, 32'h0, 1'b0);

    // A-channel encoding, held while a_ready is low.
    tl_d.a_ready = 1'b0;
    req = 2'b01; we = 2'b01; be[0] = 4'h3; addr[0] = 32'h1000_0006; wdata[0] = 32'hDEAD_BEEF;
    #1;
    check_eq("enc_avalid", tl_h.a_valid, 1'b1);
    check_eq("enc_stall_gnt", gnt, 2'b00);
    check_eq("enc_pp_op", tl_h.a_opcode, 3'h1);
    check_eq("enc_mask", tl_h.a_mask, 4'h3);
    check_eq("enc_addr", tl_h.a_address, 32'h1000_0004);
    check_eq("enc_size", tl_h.a_size, 2'd2);
    check_eq("enc_data", tl_h.a_data, 32'hDEAD_BEEF);
    check_eq("enc_instr", tl_h.a_user.instr_type, 4'h9);
    step();
    be[0] = 4'hF;
    #1; check_eq("enc_pf_op", tl_h.a_opcode, 3'h0);
    step();
    we = 2'b00;
    #1; check_eq("enc_get_op", tl_h.a_opcode, 3'h4);
    step();
    tl_d.a_ready = 1'b1; we = 2'b01; be[0] = 4'h3;
    #1; check_eq("enc_acc_gnt", gnt, 2'b01); check_eq("enc_acc_src", tl_h.a_source, 8'h01);
    step();
    #1; check_eq("rst2_gnt", gnt, 2'b01); check_eq("rst2_src", tl_h.a_source, 8'h00);
    step();

    // Reset with two outstanding: late responses are dropped.
    req = 2'b00; rst = 1'b1;
    step();
    rst = 1'b0;
    set_rsp(1'b1, 8'h01, 32'h7777_0001, 1'b0);
    #1; check_eq("late1_valid", valid, 2'b00); check_eq("late1_unexp", unexp, 1'b1);
    step();
    set_rsp(1'b1, 8'h00, 32'h7777_0000, 1'b0);
    #1; check_eq("late0_valid", valid, 2'b00); check_eq("late0_unexp", unexp, 1'b1);
    step();
    set_rsp(1'b0, 8'h00, 32'h0, 1'b0);
    req = 2'b01; we = 2'b00;
    #1;
    check_eq("post_rst_gnt", gnt, 2'b01);
    check_eq("post_rst_src", tl_h.a_source, 8'h00);
    check_eq("post_rst_unexp", unexp, 1'b0);
    step();
    req = 2'b00;

`ifdef TLUL_HOST_MUX_INTG_EN
    // Integrity codes cover the original data; one flipped data bit must be flagged.
    set_rsp(1'b1, 8'h00, 32'h2468_ACE0, 1'b0);
    tl_d.d_data = 32'h2468_ACE1;
    #1; check_eq("intg_valid", valid, 2'b01); check_eq("intg_err_o", err, 1'b1);
    step();
    set_rsp(1'b0, 8'h00, 32'h0, 1'b0);
    #1; check_eq("intg_sticky_a", intg_err, 1'b1);
    step();
    #1; check_eq("intg_sticky_b", intg_err, 1'b1);
    step();
`endif

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
